// File: rtl/rgb_light_show.sv
// rgb_light_show: switch debouncing, a four-mode pattern engine and NUM_CH
// glitch-free PWM channels in a single clock domain. Raw switches in, LED
// drives out.
module rgb_light_show #(
  parameter int NUM_CH          = 3,
  parameter int PWM_BITS        = 8,
  parameter int TICK_DIV_SLOW   = 1000000,
  parameter int TICK_DIV_FAST   = 250000,
  parameter int DEBOUNCE_CYCLES = 500000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [NUM_CH-1:0] color_switch,
  input  logic              speed_switch,
  input  logic              pattern_switch,
  output logic [NUM_CH-1:0] pwm_out,
  output logic [1:0]        mode
);

  // Debounced inputs, packed as {pattern, speed, color[NUM_CH-1:0]}.
  localparam int NUM_IN  = NUM_CH + 2;
  localparam int DB_W    = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam int DIV_MAX = (TICK_DIV_SLOW > TICK_DIV_FAST) ? TICK_DIV_SLOW : TICK_DIV_FAST;
  localparam int PS_W    = (DIV_MAX > 1) ? $clog2(DIV_MAX) : 1;
  localparam int PTR_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [PWM_BITS-1:0] MAX       = '1;
  localparam logic [DB_W-1:0]     DB_LAST   = DB_W'(DEBOUNCE_CYCLES - 1);
  localparam logic [PS_W-1:0]     SLOW_LAST = PS_W'(TICK_DIV_SLOW - 1);
  localparam logic [PS_W-1:0]     FAST_LAST = PS_W'(TICK_DIV_FAST - 1);
  localparam logic [PTR_W-1:0]    PTR_LAST  = PTR_W'(NUM_CH - 1);

  typedef enum logic [1:0] {
    MODE_STEADY  = 2'd0,
    MODE_BREATHE = 2'd1,
    MODE_CHASE   = 2'd2,
    MODE_BLINK   = 2'd3
  } mode_e;

  typedef enum logic {
    DIR_UP   = 1'b0,
    DIR_DOWN = 1'b1
  } dir_e;

  // ---------------------------------------------------------------------------
  // Debounce
  // ---------------------------------------------------------------------------
  logic [NUM_IN-1:0] raw;
  logic [NUM_IN-1:0] deb_q, deb_d;
  logic [DB_W-1:0]   db_cnt_q [NUM_IN];
  logic [DB_W-1:0]   db_cnt_d [NUM_IN];

  assign raw = {pattern_switch, speed_switch, color_switch};

  // Count cycles of disagreement; accept the raw value once it has held long enough.
  always_comb begin
    // NOTE: every variable gets its default before any branch, so no path can
    // leave a value held from a previous evaluation and infer a latch.
    for (int i = 0; i < NUM_IN; i++) begin
      deb_d[i]    = deb_q[i];
      db_cnt_d[i] = '0;
      if (raw[i] != deb_q[i]) begin
        if (db_cnt_q[i] == DB_LAST) begin
          deb_d[i] = raw[i];
        end else begin
          db_cnt_d[i] = db_cnt_q[i] + DB_W'(1);
        end
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    // NOTE: state is updated with non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    if (reset) begin
      deb_q <= '0;
      // NOTE: these arrays are plain flops rather than RAM, so they are
      // cleared in reset like any other state.
      for (int i = 0; i < NUM_IN; i++) db_cnt_q[i] <= '0;
    end else begin
      deb_q    <= deb_d;
      db_cnt_q <= db_cnt_d;
    end
  end

  logic [NUM_CH-1:0] en;
  logic              speed_fast;
  logic              pat_deb;

  assign en         = deb_q[NUM_CH-1:0];
  assign speed_fast = deb_q[NUM_CH];
  assign pat_deb    = deb_q[NUM_CH+1];

  // ---------------------------------------------------------------------------
  // Mode, step tick and pattern engine
  // ---------------------------------------------------------------------------
  mode_e              mode_q, mode_d;
  logic               pat_prev_q;
  logic [PS_W-1:0]    presc_q, presc_d;
  logic [PWM_BITS-1:0] level_q, level_d;
  dir_e               dir_q, dir_d;
  logic [PTR_W-1:0]   ptr_q, ptr_d;
  logic               phase_q, phase_d;

  logic               advance;
  logic               tick;
  logic [PS_W-1:0]    div_last;
  logic [1:0]         mode_inc;

  assign advance  = pat_deb & ~pat_prev_q;
  assign div_last = speed_fast ? FAST_LAST : SLOW_LAST;
  // >= rather than == so a switch to a shorter divider never strands the prescaler.
  assign tick     = (presc_q >= div_last);
  assign mode_inc = mode_q + 2'd1;

  // Next state: a mode advance restarts the engine and swallows any coincident tick.
  always_comb begin
    mode_d  = mode_q;
    presc_d = presc_q;
    level_d = level_q;
    dir_d   = dir_q;
    ptr_d   = ptr_q;
    phase_d = phase_q;
    if (advance) begin
      mode_d  = mode_e'(mode_inc);
      presc_d = '0;
      level_d = '0;
      dir_d   = DIR_UP;
      ptr_d   = '0;
      phase_d = 1'b1;
    end else begin
      presc_d = tick ? '0 : presc_q + PS_W'(1);
      if (tick) begin
        unique case (mode_q)
          MODE_STEADY: ;
          MODE_BREATHE: begin
            if (dir_q == DIR_UP) begin
              if (level_q == MAX) dir_d = DIR_DOWN;
              else                level_d = level_q + PWM_BITS'(1);
            end else begin
              if (level_q == '0)  dir_d = DIR_UP;
              else                level_d = level_q - PWM_BITS'(1);
            end
          end
          MODE_CHASE: ptr_d = (ptr_q == PTR_LAST) ? '0 : ptr_q + PTR_W'(1);
          MODE_BLINK: phase_d = ~phase_q;
        endcase
      end
    end
  end

  // Pattern engine state registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      mode_q     <= MODE_STEADY;
      pat_prev_q <= 1'b0;
      presc_q    <= '0;
      level_q    <= '0;
      dir_q      <= DIR_UP;
      ptr_q      <= '0;
      phase_q    <= 1'b1;
    end else begin
      mode_q     <= mode_d;
      pat_prev_q <= pat_deb;
      presc_q    <= presc_d;
      level_q    <= level_d;
      dir_q      <= dir_d;
      ptr_q      <= ptr_d;
      phase_q    <= phase_d;
    end
  end

  // ---------------------------------------------------------------------------
  // PWM
  // ---------------------------------------------------------------------------
  logic [PWM_BITS-1:0] target [NUM_CH];
  logic [PWM_BITS-1:0] cnt_q;
  logic [PWM_BITS-1:0] duty_q [NUM_CH];
  logic [NUM_CH-1:0]   pwm_q;

  // Per-channel target duty for the current mode, gated by the colour enables.
  always_comb begin
    for (int c = 0; c < NUM_CH; c++) begin
      target[c] = '0;
      unique case (mode_q)
        MODE_STEADY:  target[c] = en[c] ? MAX : '0;
        MODE_BREATHE: target[c] = en[c] ? level_q : '0;
        MODE_CHASE:   target[c] = (en[c] && ptr_q == PTR_W'(c)) ? MAX : '0;
        MODE_BLINK:   target[c] = (en[c] && phase_q) ? MAX : '0;
      endcase
    end
  end

  // Free-running counter; duties reload only at the period boundary so a
  // period is never cut short or stretched by a target change.
  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
      pwm_q <= '0;
      for (int c = 0; c < NUM_CH; c++) duty_q[c] <= '0;
    end else begin
      cnt_q <= cnt_q + PWM_BITS'(1);
      for (int c = 0; c < NUM_CH; c++) begin
        if (cnt_q == MAX) duty_q[c] <= target[c];
        pwm_q[c] <= (cnt_q < duty_q[c]);
      end
    end
  end

  assign pwm_out = pwm_q;
  assign mode    = mode_q;

endmodule

// File: tb/tb_rgb_light_show.sv
// Directed testbench for rgb_light_show with small parameters so that
// debounce, tick and PWM periods are a few cycles long.
module tb_rgb_light_show;

  localparam int NUM_CH = 3;
  localparam int PWM_BITS = 4;
  localparam int TICK_DIV_SLOW = 8;
  localparam int TICK_DIV_FAST = 2;
  localparam int DEBOUNCE_CYCLES = 4;
  localparam int PERIOD = 16;

  logic              clk = 1'b0;
  logic              reset;
  logic [NUM_CH-1:0] color_switch;
  logic              speed_switch;
  logic              pattern_switch;
  logic [NUM_CH-1:0] pwm_out;
  logic [1:0]        mode;

  int checks = 0;
  int errors = 0;
  int cyc = 0;        // posedges since reset release; equals the DUT PWM count mod 16
  int adv_cyc;        // cyc value at the edge where the last mode advance took effect
  int hi_cnt [NUM_CH];
  int bnd;

  rgb_light_show #(
    .NUM_CH(NUM_CH), .PWM_BITS(PWM_BITS), .TICK_DIV_SLOW(TICK_DIV_SLOW),
    .TICK_DIV_FAST(TICK_DIV_FAST), .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) dut (
    .clk(clk), .reset(reset), .color_switch(color_switch),
    .speed_switch(speed_switch), .pattern_switch(pattern_switch),
    .pwm_out(pwm_out), .mode(mode)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // Wait for the next period boundary, then count high samples per channel
  // over one full PWM period. bnd is the edge index where the duties loaded.
  task automatic measure_period();
    int guard = 0;
    while ((cyc % PERIOD) != 0 && guard < 2 * PERIOD) begin
      @(negedge clk);
      guard++;
    end
    bnd = cyc;
    for (int c = 0; c < NUM_CH; c++) hi_cnt[c] = 0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      for (int c = 0; c < NUM_CH; c++) hi_cnt[c] += int'(pwm_out[c]);
    end
  endtask

  // Raise pattern_switch and hold it through acceptance; checks mode is
  // still old one edge before the advance and new exactly on it.
  task automatic press_pattern(input logic [1:0] new_mode);
    logic [1:0] old_mode;
    old_mode = new_mode - 2'd1;
    pattern_switch = 1'b1;
    repeat (DEBOUNCE_CYCLES) @(negedge clk);
    checks++;
    if (mode !== old_mode) begin
      errors++;
      $display("FAIL press_early_%0d: mode=%0d expected %0d", new_mode, mode, old_mode);
    end
    @(negedge clk);
    checks++;
    if (mode !== new_mode) begin
      errors++;
      $display("FAIL press_adv_%0d: mode=%0d expected %0d", new_mode, mode, new_mode);
    end
    adv_cyc = cyc;
  endtask

  task automatic release_pattern();
    pattern_switch = 1'b0;
    repeat (2 * DEBOUNCE_CYCLES) @(negedge clk);
  endtask

  task automatic test_reset();
    reset = 1'b1;
    color_switch = '0;
    speed_switch = 1'b0;
    pattern_switch = 1'b0;
    repeat (3) @(negedge clk);
    checks++;
    if (pwm_out !== 3'b000) begin
      errors++;
      $display("FAIL reset_pwm: pwm_out=%b expected 000", pwm_out);
    end
    checks++;
    if (mode !== 2'd0) begin
      errors++;
      $display("FAIL reset_mode: mode=%0d expected 0", mode);
    end
    reset = 1'b0;
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== 3'b000) begin
        errors++;
        $display("FAIL reset_idle cyc %0d: pwm_out=%b expected 000", cyc, pwm_out);
      end
    end
  endtask

  task automatic test_steady();
    color_switch = 3'b101;
    repeat (6) @(negedge clk);
    for (int p = 0; p < 2; p++) begin
      measure_period();
      checks++;
      if (hi_cnt[0] !== 15 || hi_cnt[1] !== 0 || hi_cnt[2] !== 15) begin
        errors++;
        $display("FAIL steady_duty b=%0d: high=%0d/%0d/%0d expected 15/0/15",
                 bnd, hi_cnt[0], hi_cnt[1], hi_cnt[2]);
      end
    end
    checks++;
    if (mode !== 2'd0) begin
      errors++;
      $display("FAIL steady_mode: mode=%0d expected 0", mode);
    end
  endtask

  task automatic test_mode_advance();
    // Three cycles of high is one short of acceptance.
    pattern_switch = 1'b1;
    repeat (3) @(negedge clk);
    pattern_switch = 1'b0;
    repeat (10) @(negedge clk);
    checks++;
    if (mode !== 2'd0) begin
      errors++;
      $display("FAIL short_pulse: mode=%0d expected 0", mode);
    end
    press_pattern(2'd1);
    repeat (10) @(negedge clk);
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL held_no_readvance: mode=%0d expected 1", mode);
    end
  endtask

  task automatic test_breathe();
    int k;
    int exp_lvl;
    pattern_switch = 1'b0;   // falling edge must not advance
    color_switch = 3'b001;
    repeat (12) @(negedge clk);
    for (int p = 0; p < 18; p++) begin
      measure_period();
      k = ((bnd - 1 - adv_cyc) / TICK_DIV_SLOW) % 32;
      exp_lvl = (k <= 15) ? k : 31 - k;
      checks++;
      if (hi_cnt[0] !== exp_lvl || hi_cnt[1] !== 0 || hi_cnt[2] !== 0) begin
        errors++;
        $display("FAIL breathe_duty b=%0d: high=%0d/%0d/%0d expected %0d/0/0",
                 bnd, hi_cnt[0], hi_cnt[1], hi_cnt[2], exp_lvl);
      end
    end
    checks++;
    if (mode !== 2'd1) begin
      errors++;
      $display("FAIL breathe_mode: mode=%0d expected 1", mode);
    end
  endtask

  task automatic test_chase();
    int active;
    int prev;
    int n_on;
    bit clean;
    press_pattern(2'd2);
    pattern_switch = 1'b0;
    speed_switch = 1'b1;
    color_switch = 3'b111;
    repeat (12) @(negedge clk);
    prev = -1;
    for (int p = 0; p < 6; p++) begin
      measure_period();
      n_on = 0;
      clean = 1'b1;
      active = -1;
      for (int c = 0; c < NUM_CH; c++) begin
        if (hi_cnt[c] == 15) begin
          n_on++;
          active = c;
        end else if (hi_cnt[c] != 0) begin
          clean = 1'b0;
        end
      end
      checks++;
      if (n_on != 1 || !clean) begin
        errors++;
        $display("FAIL chase_onehot b=%0d: high=%0d/%0d/%0d expected one 15, rest 0",
                 bnd, hi_cnt[0], hi_cnt[1], hi_cnt[2]);
      end
      // 16 clk per period at 2 clk per step: pointer moves 8 = 2 (mod 3).
      if (prev >= 0) begin
        checks++;
        if (active != (prev + 2) % NUM_CH) begin
          errors++;
          $display("FAIL chase_rotate b=%0d: channel %0d expected %0d",
                   bnd, active, (prev + 2) % NUM_CH);
        end
      end
      prev = active;
    end
  endtask

  task automatic test_reset_mid_chase();
    int guard = 0;
    while (dut.ptr_q !== 2'd2 && guard < 20) begin
      @(negedge clk);
      guard++;
    end
    checks++;
    if (dut.ptr_q !== 2'd2) begin
      errors++;
      $display("FAIL chase_ptr_reach: ptr=%0d expected 2 within 20 cycles", dut.ptr_q);
    end
    reset = 1'b1;
    @(negedge clk);
    checks++;
    if (pwm_out !== 3'b000 || mode !== 2'd0) begin
      errors++;
      $display("FAIL reset_mid: pwm_out=%b mode=%0d expected 000 and 0", pwm_out, mode);
    end
    @(negedge clk);
    reset = 1'b0;
    // Counters restart: duties stay 0 until the first boundary at edge 16.
    for (int i = 0; i < PERIOD; i++) begin
      @(negedge clk);
      checks++;
      if (pwm_out !== 3'b000) begin
        errors++;
        $display("FAIL restart_idle cyc %0d: pwm_out=%b expected 000", cyc, pwm_out);
      end
    end
    measure_period();
    checks++;
    if (bnd != 16 || hi_cnt[0] !== 15 || hi_cnt[1] !== 15 || hi_cnt[2] !== 15) begin
      errors++;
      $display("FAIL restart_steady b=%0d: high=%0d/%0d/%0d expected 15/15/15 at b=16",
               bnd, hi_cnt[0], hi_cnt[1], hi_cnt[2]);
    end
  endtask

  task automatic test_blink_speed_change();
    int j;
    int t;
    logic exp_phase;
    speed_switch = 1'b0;
    repeat (8) @(negedge clk);
    press_pattern(2'd1);
    release_pattern();
    press_pattern(2'd2);
    release_pattern();
    press_pattern(2'd3);
    // Speed goes fast so the debounced value lands when the prescaler is 6.
    repeat (2) @(negedge clk);
    speed_switch = 1'b1;
    pattern_switch = 1'b0;
    repeat (4) @(negedge clk);
    checks++;
    if (int'(dut.presc_q) != 6 || dut.phase_q !== 1'b1) begin
      errors++;
      $display("FAIL blink_presc6: presc=%0d phase=%b expected 6 and 1",
               dut.presc_q, dut.phase_q);
    end
    // Tick on the very next edge, then every second edge.
    for (j = 7; j <= 12; j++) begin
      @(negedge clk);
      t = (j - 7) / 2 + 1;
      exp_phase = ((t % 2) == 0);
      checks++;
      if (dut.phase_q !== exp_phase) begin
        errors++;
        $display("FAIL blink_phase +%0d: phase=%b expected %b", j, dut.phase_q, exp_phase);
      end
    end
    measure_period();
    t = (bnd - 1 - adv_cyc - 7) / 2 + 1;
    exp_phase = ((t % 2) == 0);
    checks++;
    if (hi_cnt[0] !== (exp_phase ? 15 : 0) || hi_cnt[1] !== (exp_phase ? 15 : 0) ||
        hi_cnt[2] !== (exp_phase ? 15 : 0)) begin
      errors++;
      $display("FAIL blink_duty b=%0d: high=%0d/%0d/%0d expected all %0d",
               bnd, hi_cnt[0], hi_cnt[1], hi_cnt[2], exp_phase ? 15 : 0);
    end
    checks++;
    if (mode !== 2'd3) begin
      errors++;
      $display("FAIL blink_mode: mode=%0d expected 3", mode);
    end
  endtask

  initial begin
    test_reset();
    test_steady();
    test_mode_advance();
    test_breathe();
    test_chase();
    test_reset_mid_chase();
    test_blink_speed_change();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/rgb_light_show.md
Name: rgb_light_show

Overview:
- Parametrised successor to the fixed 3-channel RGB light-show path.
- Integrates per-input debouncing, a selectable pattern engine and NUM_CH glitch-free PWM channels in one clocked block.
- Raw board switches in, PWM LED drives out. Sits directly between the switch pins and the LED pins in the top-level.

Parameters:
- NUM_CH, 3: number of PWM channels and colour-enable switches.
- PWM_BITS, 8: PWM counter and duty width. MAX = 2^PWM_BITS-1.
- TICK_DIV_SLOW, 1000000: clk cycles per pattern step when speed is slow.
- TICK_DIV_FAST, 250000: clk cycles per pattern step when speed is fast.
- DEBOUNCE_CYCLES, 500000: consecutive stable samples required to accept a switch change.

Ports:
- clk  input  1  system clock; single clock domain.
- reset  input  1  synchronous, active-high reset.
- color_switch  input  NUM_CH  raw per-channel enable switches.
- speed_switch  input  1  raw switch; 0 = slow, 1 = fast.
- pattern_switch  input  1  raw switch; each accepted rising edge advances the mode.
- pwm_out  output  NUM_CH  registered PWM drive, one bit per channel.
- mode  output  2  current mode: 0 STEADY, 1 BREATHE, 2 CHASE, 3 BLINK.

Behaviour:
- Reset, sampled on a clk edge with reset=1, clears all of the following:
  - pwm_out=0, mode=STEADY.
  - Debounced values=0 and debounce counters=0.
  - Prescaler=0, PWM counter=0, all duties=0.
  - level=0, dir=up, ptr=0, phase=1.
- Reset mid-operation aborts everything; there is no partial state.
- Debounce, independent per input (NUM_CH+2 instances):
  - Counter increments while raw != debounced value, clears when they are equal.
  - On reaching DEBOUNCE_CYCLES-1 the debounced value takes raw and the counter clears.
  - Net latency is DEBOUNCE_CYCLES cycles of stable input. A bounce shorter than that never propagates.
- Mode advance:
  - A debounced pattern_switch 0->1 advances mode STEADY->BREATHE->CHASE->BLINK->STEADY.
  - A falling edge has no effect.
  - On each advance: prescaler=0, level=0, dir=up, ptr=0, phase=1.
- Step tick:
  - Prescaler counts 0..DIV-1, where DIV = TICK_DIV_FAST if debounced speed=1, else TICK_DIV_SLOW.
  - A one-cycle tick is issued at DIV-1, then the prescaler wraps to 0.
  - A speed change mid-count: if prescaler >= new DIV-1, tick next cycle and wrap. No lockup.
- Pattern engine, per mode; target[c] is gated by en[c] = debounced color_switch[c]:
  - STEADY: target = en ? MAX : 0. Ticks are ignored.
  - BREATHE: on each tick, level moves by 1 in direction dir.
    - At level=MAX with dir=up: dir flips to down and level stays at MAX for that tick.
    - At 0 with dir=down: symmetric, flips to up. Triangle period = 2*MAX+2 ticks.
    - target = en ? level : 0.
  - CHASE: ptr steps 0..NUM_CH-1 and wraps to 0, one step per tick. It advances even through disabled channels.
    - target = (c==ptr && en) ? MAX : 0.
  - BLINK: phase toggles each tick. target = (en && phase) ? MAX : 0.
- A tick and a mode advance in the same cycle: the mode advance wins and the tick is dropped.
- PWM:
  - cnt is a free-running PWM_BITS counter that wraps MAX->0.
  - Duty register duty[c] loads target[c] only in the cycle where cnt==MAX, so updates are glitch-free and take effect from the next period.
  - Registered output: pwm_out[c] <= (cnt < duty[c]).
  - duty=0 gives a constant 0. duty=MAX gives high MAX of every 2^PWM_BITS cycles.
  - High time per period equals duty exactly.
- Output timing: pwm_out lags (cnt, duty) by one cycle. mode is registered and updates the cycle after the accepted edge.

Test Plan (PWM_BITS=4, TICK_DIV_SLOW=8, TICK_DIV_FAST=2, DEBOUNCE_CYCLES=4, NUM_CH=3):
- Reset, then color_switch=3'b101 held in STEADY -> after debounce plus the next period boundary, pwm_out[0] and pwm_out[2] are high 15 of every 16 cycles, pwm_out[1] stays 0, mode=0.
- Pulse pattern_switch high for 3 cycles -> mode stays 0. Hold it high for 4+ cycles -> mode=1 exactly once, and holding longer gives no further advance.
- BREATHE, slow, color=3'b001 -> duty[0] sampled at successive period boundaries rises 0..15 then falls back, with one tick at 15 and one at 0. Period = 32 ticks = 256 clk.
- CHASE, fast, color=3'b111 -> ptr advances every 2 clk. pwm_out shows one-hot channel activity rotating 0->1->2->0, with duties latched only at cnt==15.
- BLINK: toggle speed_switch slow->fast while prescaler=6 -> tick on the next cycle, then every 2 cycles. phase alternates and duty alternates 15/0.
- Assert reset while in CHASE with ptr=2 -> next cycle pwm_out=0 and mode=0. After release, all counters restart from 0.
